// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg_scan_pkg;

    // Width of one octal display digit.
    localparam int unsigned DIGIT_W = 3;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        BLANK
    } scan_state_e;

endpackage

// File: rtl/seg_dwell_timer.sv
// Loadable down-counter with a zero flag; times both digit dwell and inter-digit blanking.
module seg_dwell_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/seg_scanner.sv
// Multiplexed display scanner: steps through NUM_DIGITS octal digits with dwell and blanking
// periods, optional leading-zero suppression, and a frame-synchronous load handshake.
module seg_scanner
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          run,
    input  logic                          lz_blank,
    input  logic                          load_valid,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_data,
    output logic                          load_ready,
    output logic [DIGIT_W-1:0]            segin,
    output logic                          seg_en,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          frame_done
);

    localparam int unsigned DataW  = DIGIT_W * NUM_DIGITS;
    localparam int unsigned MaxCyc = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc);
    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);
    localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL_CYCLES - 1);
    localparam logic [CntW-1:0] BlankLoad = CntW'(BLANK_CYCLES - 1);

    // Display data path
    logic [DataW-1:0] display_q, display_d;
    logic [DataW-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             commit;
    logic             accept;

    // Sequencer
    scan_state_e          state_q, state_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [DIGIT_W-1:0]   segin_q, segin_d;
    logic                 seg_en_q, seg_en_d;
    logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic                 frame_done_q, frame_done_d;

    // Timer interface
    logic            tmr_load;
    logic [CntW-1:0] tmr_val;
    logic [CntW-1:0] tmr_count;
    logic            tmr_zero;

    // Digit decode helpers
    logic [DIGIT_W-1:0]    disp_digits [NUM_DIGITS];
    logic                  upper_zero;
    logic                  suppress;
    logic [NUM_DIGITS-1:0] sel_onehot;

    seg_dwell_timer #(
        .CNT_W (CntW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .count_o    (tmr_count),
        .zero_o     (tmr_zero)
    );

    assign load_ready = !pending_q;
    assign accept     = load_valid && !pending_q;
    // Pending data only lands between frames, or straight away while idle.
    assign commit     = pending_q && ((state_q == IDLE) || frame_done_q);

    // Shadow capture on handshake, display update on commit.
    always_comb begin
        display_d = display_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (commit) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end else if (accept) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end
    end

    // Display, shadow and pending flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_q <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            display_q <= display_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    // Scan sequencing: next state, digit index, timer reloads and end-of-frame pulse.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = DwellLoad;
        if (!run) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = SHOW;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end
                SHOW: begin
                    if (tmr_zero) begin
                        state_d  = BLANK;
                        tmr_load = 1'b1;
                        tmr_val  = BlankLoad;
                        // A single blank cycle is also the final one.
                        frame_done_d = (idx_q == LastIdx) && (BLANK_CYCLES == 1);
                    end
                end
                BLANK: begin
                    if (tmr_zero) begin
                        state_d  = SHOW;
                        tmr_load = 1'b1;
                        idx_d    = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
                    end else begin
                        frame_done_d = (idx_q == LastIdx) && (tmr_count == CntW'(1));
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Leading-zero test for the digit about to be shown.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            disp_digits[i] = display_d[DIGIT_W*i +: DIGIT_W];
            if ((i >= int'(idx_d)) && (disp_digits[i] != '0)) begin
                upper_zero = 1'b0;
            end
        end
        suppress = lz_blank && (idx_d != '0) && upper_zero;
    end

    // Decoder code/enable for the coming cycle; digit drive trails them by one cycle.
    always_comb begin
        segin_d  = segin_q;
        seg_en_d = 1'b0;
        if (state_d == SHOW) begin
            segin_d  = disp_digits[idx_d];
            seg_en_d = !suppress;
        end
        sel_onehot  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
        digit_sel_d = seg_en_q ? ~sel_onehot : '1;
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            segin_q      <= '0;
            seg_en_q     <= 1'b0;
            digit_sel_q  <= '1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            segin_q      <= segin_d;
            seg_en_q     <= seg_en_d;
            digit_sel_q  <= digit_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segin      = segin_q;
    assign seg_en     = seg_en_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule
